dpram_be: RTL and testbench

Parametrised dual-port RAM, successor to the plain FIFO storage array. Adds per-byte write enables, write-to-read forwarding on same-address collisions, a selectable 1- or 2-cycle read pipeline with `rd_valid`, out-of-range address detection and a sequential hardware clear engine. It sits under the FIFO controllers and any block needing simple one-write/one-read storage.

---
 rtl/dpram_pkg.sv | 18 +
 rtl/dpram_if.sv | 32 +++
 rtl/dpram_clear_ctrl.sv | 47 ++++
 rtl/dpram_be.sv | 148 ++++++++++++++
 tb/tb_dpram_be.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
// Optional lane parity is enabled with `define DPRAM_PARITY_EN.
package dpram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Even parity of one lane; lanes narrower than 64 bits are zero-extended by the caller.
    function automatic logic byte_par(input logic [63:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/dpram_if.sv
// Write/read/clear bus of dpram_be; master drives requests, slave returns read data and status.
interface dpram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTES-1:0]  wr_be;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  addr_err;
    logic                  par_err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, clr_busy, addr_err, par_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, clr_busy, addr_err, par_err
    );

endinterface

// File: rtl/dpram_clear_ctrl.sv
// Clear sequencer: on clr_req walks addresses 0..DEPTH-1, one word per cycle, with clr_busy high.
module dpram_clear_ctrl
    import dpram_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_we,
    output logic [CNT_W-1:0] clr_addr
);

    clr_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DEPTH - 1)) begin
                        state    <= ST_IDLE;
                        clr_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign clr_we   = clr_busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/dpram_be.sv
// Dual-port RAM with byte enables, same-address write forwarding, 1/2-cycle read pipeline,
// range checking and a hardware clear. `define DPRAM_PARITY_EN adds per-lane even parity.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 1
) (
    input logic     clk,
    input logic     rst_n,
    dpram_if.slave  bus
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int STAGES    = RD_LATENCY - 1;

    if (RD_LATENCY != RD_LAT_MIN && RD_LATENCY != RD_LAT_MAX) begin : g_bad_lat
        $error("dpram_be: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("dpram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DEPTH < 2 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
        $error("dpram_be: DEPTH out of range");
    end

    typedef logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] word_t;

    word_t              mem [DEPTH];
    word_t              wd, rd_word;
    logic [NUM_BYTES-1:0] fwd;
    logic               clr_busy, clr_we;
    logic [IDX_W-1:0]   clr_addr, wa, ra;
    logic               idle, wr_in, rd_in, wr_ok, wr_err0, rd_go, rd_err0, coll;

    dpram_clear_ctrl #(.DEPTH(DEPTH)) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign idle    = !clr_busy;
    assign wr_in   = {1'b0, bus.wr_addr} < (ADDR_WIDTH+1)'(DEPTH);
    assign rd_in   = {1'b0, bus.rd_addr} < (ADDR_WIDTH+1)'(DEPTH);
    assign wr_ok   = bus.wr_en & idle & wr_in;
    assign wr_err0 = bus.wr_en & idle & !wr_in;
    assign rd_go   = bus.rd_en & idle;
    assign rd_err0 = rd_go & !rd_in;
    assign coll    = wr_ok & rd_in & (bus.wr_addr == bus.rd_addr);
    assign wa      = bus.wr_addr[IDX_W-1:0];
    assign ra      = bus.rd_addr[IDX_W-1:0];
    assign wd      = bus.wr_data;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (bus.wr_be[i]) mem[wa][i] <= wd[i];
        end
    end

    // Colliding lanes are taken from the write bus so the RAM's read-during-write behaviour never matters.
    always_comb begin
        rd_word = '0;
        fwd     = '0;
        if (rd_in) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                fwd[i]     = coll & bus.wr_be[i];
                rd_word[i] = fwd[i] ? wd[i] : mem[ra][i];
            end
        end
    end

    // vld/aerr shift every cycle; data stages load only on a valid so rd_data holds between reads.
    logic [STAGES:0] vld_pipe, aerr_pipe;
    word_t           data_pipe [STAGES+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            aerr_pipe <= '0;
            for (int k = 0; k <= STAGES; k++) data_pipe[k] <= '0;
        end else begin
            vld_pipe[0]  <= rd_go;
            aerr_pipe[0] <= rd_err0 | ((STAGES == 0) ? wr_err0 : 1'b0);
            if (rd_go) data_pipe[0] <= rd_word;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                aerr_pipe[k] <= aerr_pipe[k-1] | ((k == STAGES) ? wr_err0 : 1'b0);
                if (vld_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
            end
        end
    end

    assign bus.rd_data  = data_pipe[STAGES];
    assign bus.rd_valid = vld_pipe[STAGES];
    assign bus.addr_err = aerr_pipe[STAGES];
    assign bus.clr_busy = clr_busy;

`ifdef DPRAM_PARITY_EN
    logic [NUM_BYTES-1:0] par_mem [DEPTH];
    logic [NUM_BYTES-1:0] wr_par, mism;
    logic                 perr0;
    logic [STAGES:0]      perr_pipe;

    always_comb begin
        wr_par = '0;
        mism   = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            wr_par[i] = byte_par(64'(wd[i]));
            if (rd_in) mism[i] = !fwd[i] & (byte_par(64'(mem[ra][i])) ^ par_mem[ra][i]);
        end
    end

    assign perr0 = rd_go & (|mism);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (bus.wr_be[i]) par_mem[wa][i] <= wr_par[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_pipe <= '0;
        end else begin
            perr_pipe[0] <= perr0;
            for (int k = 1; k <= STAGES; k++) perr_pipe[k] <= perr_pipe[k-1];
        end
    end

    assign bus.par_err = perr_pipe[STAGES];
`else
    assign bus.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_be.sv
// Scoreboard bench for dpram_be: one RD_LATENCY=1 and one RD_LATENCY=2 instance driven in lockstep.
module tb_dpram_be;
    import dpram_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   busy_lo = 0;
    int   busy_hi = -1;

`ifdef DPRAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dpram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5)) b1 ();
    dpram_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5)) b2 ();

    dpram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(16), .RD_LATENCY(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    dpram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(16), .RD_LATENCY(2))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        int          dut;
        int          due;
        bit          vld;
        logic [31:0] data;
        bit          aerr;
        bit          perr;
    } ev_t;

    ev_t sb[$];

    task automatic push(int d, int due, bit vld, logic [31:0] data, bit aerr, bit perr);
        ev_t e;
        e.dut = d; e.due = due; e.vld = vld; e.data = data; e.aerr = aerr; e.perr = perr;
        sb.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pops every expected event due this cycle for one DUT; coincident events merge into one pulse.
    task automatic mon(int d, logic vld, logic aerr, logic perr, logic [31:0] data);
        bit          ev, ea, ep;
        logic [31:0] ed;
        int          i;
        ev = 0; ea = 0; ep = 0; ed = '0; i = 0;
        while (i < sb.size()) begin
            if (sb[i].dut == d && sb[i].due <= cyc) begin
                if (sb[i].due < cyc) begin
                    n_tests++; n_fail++;
                    $display("FAIL stale dut%0d: event due %0d unserved at %0d", d, sb[i].due, cyc);
                end else begin
                    ev |= sb[i].vld; ea |= sb[i].aerr; ep |= sb[i].perr;
                    if (sb[i].vld) ed = sb[i].data;
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
        if (ev || ea || ep || vld || aerr || perr) begin
            n_tests++;
            if (vld !== ev || aerr !== ea || perr !== ep || (ev && data !== ed)) begin
                n_fail++;
                $display("FAIL rsp dut%0d cyc %0d: got vld=%b aerr=%b perr=%b data=%h expected vld=%b aerr=%b perr=%b data=%h",
                         d, cyc, vld, aerr, perr, data, ev, ea, ep, ed);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            bit eb;
            mon(0, b1.rd_valid, b1.addr_err, b1.par_err, b1.rd_data);
            mon(1, b2.rd_valid, b2.addr_err, b2.par_err, b2.rd_data);
            eb = (cyc >= busy_lo) && (cyc <= busy_hi);
            if (eb || b1.clr_busy) chk("clr_busy u1", 32'(b1.clr_busy), 32'(eb));
            if (eb || b2.clr_busy) chk("clr_busy u2", 32'(b2.clr_busy), 32'(eb));
        end
    end

    task automatic drive(bit we, int wa, logic [31:0] wd, logic [3:0] be, bit re, int ra, bit clr);
        b1.wr_en = we; b1.wr_addr = 5'(wa); b1.wr_data = wd; b1.wr_be = be;
        b1.rd_en = re; b1.rd_addr = 5'(ra); b1.clr_req = clr;
        b2.wr_en = we; b2.wr_addr = 5'(wa); b2.wr_data = wd; b2.wr_be = be;
        b2.rd_en = re; b2.rd_addr = 5'(ra); b2.clr_req = clr;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of requests and queue the responses each DUT owes.
    task automatic op(bit we, int wa, logic [31:0] wd, logic [3:0] be, bit re, int ra, bit clr,
                      bit ev, logic [31:0] ed, bit era, bit ewa, bit ep);
        drive(we, wa, wd, be, re, ra, clr);
        for (int d = 0; d < 2; d++) begin
            if (ev)  push(d, cyc + d + 1, 1'b1, ed, era, ep);
            if (ewa) push(d, cyc + 1, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        step;
        drive(0, 0, 32'h0, 4'h0, 0, 0, 0);
    endtask

    task automatic wr(int a, logic [31:0] d, logic [3:0] be);
        op(1, a, d, be, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic rd(int a, logic [31:0] exp, bit era, bit ep);
        op(0, 0, 32'h0, 4'h0, 1, a, 0, 1, exp, era, 0, ep);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, " rd_data u1"},  b1.rd_data, 32'h0);
        chk({tag, " rd_valid u1"}, 32'(b1.rd_valid), 32'h0);
        chk({tag, " clr_busy u1"}, 32'(b1.clr_busy), 32'h0);
        chk({tag, " addr_err u1"}, 32'(b1.addr_err), 32'h0);
        chk({tag, " par_err u1"},  32'(b1.par_err), 32'h0);
        chk({tag, " rd_data u2"},  b2.rd_data, 32'h0);
        chk({tag, " rd_valid u2"}, 32'(b2.rd_valid), 32'h0);
        chk({tag, " clr_busy u2"}, 32'(b2.clr_busy), 32'h0);
        chk({tag, " addr_err u2"}, 32'(b2.addr_err), 32'h0);
        chk({tag, " par_err u2"},  32'(b2.par_err), 32'h0);
        chk({tag, " fsm u1"}, 32'(u1.u_clr.state), 32'(ST_IDLE));
        chk({tag, " fsm u2"}, 32'(u2.u_clr.state), 32'(ST_IDLE));
    endtask

    function automatic logic [31:0] fv(int i);
        return {8'h5A, 8'(i), 8'(~i), 8'(i * 3)};
    endfunction

    initial begin
        int k;
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 4'h0, 0, 0, 0);
        repeat (3) step;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step;

        // byte-enable merge
        wr(3, 32'hAABBCCDD, 4'hF);
        wr(3, 32'h11223344, 4'b0101);
        rd(3, 32'hAA22CC44, 0, 0);

        // same-address collision forwards enabled lanes
        wr(5, 32'h0, 4'hF);
        op(1, 5, 32'hDEADBEEF, 4'b0011, 1, 5, 0, 1, 32'h0000BEEF, 0, 0, 0);
        rd(5, 32'h0000BEEF, 0, 0);

        // back-to-back reads at full throughput
        for (int i = 0; i < 16; i++) wr(i, fv(i), 4'hF);
        for (int i = 0; i < 16; i++) rd(i, fv(i), 0, 0);

        // out-of-range accesses; write to 20 must not alias onto 4
        rd(16, 32'h0, 1, 0);
        rd(20, 32'h0, 1, 0);
        op(1, 20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 32'h0, 0, 1, 0);
        op(1, 20, 32'hFFFFFFFF, 4'hF, 1, 21, 0, 1, 32'h0, 1, 1, 0);
        rd(4, fv(4), 0, 0);
        rd(15, fv(15), 0, 0);

        // full clear with a same-cycle read and ignored traffic during CLEAR
        for (int i = 0; i < 16; i++) wr(i, 32'hFFFFFFFF, 4'hF);
        k = cyc;
        busy_lo = k + 1;
        busy_hi = k + 16;
        op(0, 0, 32'h0, 4'h0, 1, 2, 1, 1, 32'hFFFFFFFF, 0, 0, 0);
        for (int j = 0; j < 16; j++) op(1, j, 32'h12345678, 4'hF, 1, j, 1, 0, 32'h0, 0, 0, 0);
        chk("first accept cycle", 32'(cyc), 32'(k + 17));
        for (int i = 0; i < 16; i++) rd(i, 32'h0, 0, 0);

        // reset in the middle of a clear
        k = cyc;
        busy_lo = k + 1;
        busy_hi = k + 16;
        op(0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 32'h0, 0, 0, 0);
        for (int g = 0; g < 20 && cyc < k + 7; g++) step;
        rst_n = 1'b0;
        busy_hi = k + 6;
        sb.delete();
        #2;
        chk_reset_outputs("mid-clear reset");
        step;
        step;
        rst_n = 1'b1;
        step;
        wr(7, 32'hCAFEF00D, 4'hF);
        rd(7, 32'hCAFEF00D, 0, 0);

        // parity: corrupt lane-1 parity of address 2
        wr(2, 32'h01020304, 4'hF);
        wr(6, 32'h0A0B0C0D, 4'hF);
`ifdef DPRAM_PARITY_EN
        u1.par_mem[2][1] = ~u1.par_mem[2][1];
        u2.par_mem[2][1] = ~u2.par_mem[2][1];
`endif
        rd(2, 32'h01020304, 0, PAR);
        rd(6, 32'h0A0B0C0D, 0, 0);
        step;
        step;
        chk("hold rd_data u1", b1.rd_data, 32'h0A0B0C0D);
        chk("hold rd_data u2", b2.rd_data, 32'h0A0B0C0D);

        repeat (4) step;
        chk("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
